seg_scan_driver: RTL and testbench

Time-multiplexed seven-segment display driver that sits directly downstream of the cascaded BCD/hex up/down counter digits. It takes the packed 4-bit values of up to eight counter digits and scans them onto the board's common-anode display: one digit lit per refresh slot, with hex decoding, per-digit enable, decimal points and optional leading-zero blanking. Inputs are snapshotted once per frame, so a counter carry that ripples across several digits never shows a torn value.

---
 rtl/seg_pkg.sv | 21 ++
 rtl/hex_to_seg.sv | 12 +
 rtl/seg_scan_driver.sv | 127 ++++++++++++
 tb/tb_seg_scan_driver.sv | 130 +++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan driver: digit width, blank code
// and the active-low {g,f,e,d,c,b,a} glyph table for hex digits.
package seg_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entry n is the glyph for value n; listed from F down to 0.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  function automatic logic [6:0] seg_lookup(input logic [DIGIT_W-1:0] value);
    return SEG_TABLE[value];
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational 4-bit value to active-low seven-segment glyph.
// Values above 9 decode as A,b,C,d,E,F so the same driver serves BCD and hex counters.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [DIGIT_W-1:0] value,
  output logic [6:0]         seg
);

  assign seg = seg_lookup(value);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver. Digit inputs are snapshotted
// once per frame so a rippling counter carry never shows a torn value.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                          clkSignal,
  input  logic                          rst,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic                          blank_lz,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [6:0]                    seg,
  output logic                          dp
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LIT  = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]              cnt;
  logic [IDX_W-1:0]              idx;
  logic                          slot_end;
  logic                          frame_end;

  logic [DIGIT_W*NUM_DIGITS-1:0] snap_dig;
  logic [NUM_DIGITS-1:0]         snap_en;
  logic [NUM_DIGITS-1:0]         snap_dp;
  logic                          load;

  logic [NUM_DIGITS-1:0]         is_zero;
  logic [NUM_DIGITS-1:0]         lz_mask;
  logic                          lz_run;

  logic [DIGIT_W-1:0]            cur_dig;
  logic [6:0]                    cur_seg;
  logic                          lit;
  logic [NUM_DIGITS-1:0]         an_nxt;
  logic [6:0]                    seg_nxt;
  logic                          dp_nxt;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  always_ff @(posedge clkSignal or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= frame_end ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Capture once right after reset, then only as the scan wraps back to digit 0.
  always_ff @(posedge clkSignal or negedge rst) begin
    if (!rst) begin
      snap_dig <= '0;
      snap_en  <= '0;
      snap_dp  <= '0;
      load     <= 1'b1;
    end else begin
      load <= 1'b0;
      if (load || frame_end) begin
        snap_dig <= digits;
        snap_en  <= digit_en;
        snap_dp  <= dp_in;
      end
    end
  end

  // Walk down from the most significant digit; a disabled digit reads as zero.
  always_comb begin
    is_zero = '0;
    lz_mask = '0;
    lz_run  = blank_lz;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      is_zero[i] = (snap_dig[i*DIGIT_W +: DIGIT_W] == '0) || !snap_en[i];
    end
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lz_run     = lz_run && is_zero[i];
      lz_mask[i] = lz_run;
    end
  end

  assign cur_dig = snap_dig[idx*DIGIT_W +: DIGIT_W];

  hex_to_seg u_hex_to_seg (
    .value (cur_dig),
    .seg   (cur_seg)
  );

  assign lit = (cnt >= CNT_LIT) && snap_en[idx] && !lz_mask[idx];

  always_comb begin
    an_nxt  = '1;
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b1;
    if (lit) begin
      an_nxt[idx] = 1'b0;
      seg_nxt     = cur_seg;
      dp_nxt      = ~snap_dp[idx];
    end
  end

  always_ff @(posedge clkSignal or negedge rst) begin
    if (!rst) begin
      an  <= '1;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with 4 digits, 4-clock slots and a 1-clock guard.
module tb_seg_scan_driver;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int BL = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [15:0]   digits = '0;
  logic [ND-1:0] digit_en = '0;
  logic [ND-1:0] dp_in = '0;
  logic          blank_lz = 1'b0;
  logic [ND-1:0] an;
  logic [6:0]    seg;
  logic          dp;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [11:0] DARK = {4'hF, 7'h7F, 1'b1};

  seg_scan_driver #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BL)
  ) dut (
    .clkSignal (clk),
    .rst       (rst),
    .digits    (digits),
    .digit_en  (digit_en),
    .dp_in     (dp_in),
    .blank_lz  (blank_lz),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reset with new inputs; release lands on a falling edge so the next rise is edge 1.
  task automatic apply_reset(input logic [15:0] d, input logic [3:0] en,
                             input logic [3:0] dpi, input logic lz);
    rst      = 1'b0;
    digits   = d;
    digit_en = en;
    dp_in    = dpi;
    blank_lz = lz;
    @(negedge clk);
    chk("reset_dark", {20'h0, an, seg, dp}, {20'h0, DARK});
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One slot: BL guard clocks, then RD-BL lit clocks; sampled 1 time unit after each edge.
  task automatic run_slot(input string tag, input int s, input logic [6:0] sg,
                          input logic lt, input logic dpb);
    logic [3:0]  a_exp;
    logic [11:0] exp;
    a_exp    = 4'hF;
    a_exp[s] = 1'b0;
    exp = lt ? {a_exp, sg, ~dpb} : DARK;
    for (int k = 0; k < RD; k++) begin
      @(posedge clk);
      #1;
      if (k < BL) chk($sformatf("%s d%0d guard", tag, s), {20'h0, an, seg, dp}, {20'h0, DARK});
      else        chk($sformatf("%s d%0d lit%0d", tag, s, k), {20'h0, an, seg, dp}, {20'h0, exp});
    end
  endtask

  task automatic run_frame(input string tag, input logic [27:0] segs,
                           input logic [3:0] lt, input logic [3:0] dpm);
    for (int s = 0; s < ND; s++) run_slot(tag, s, segs[7*s +: 7], lt[s], dpm[s]);
  endtask

  initial begin
    // scan order 1234: digit 0 shows 4
    apply_reset(16'h1234, 4'hF, 4'h0, 1'b0);
    run_frame("scan1234_f0", {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 4'h0);
    run_frame("scan1234_f1", {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 4'h0);

    // asynchronous reset while digit 0 is lit
    run_slot("pre_reset", 0, 7'h19, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    chk("async_reset_dark", {20'h0, an, seg, dp}, {20'h0, DARK});
    @(negedge clk);
    chk("reset_hold_dark", {20'h0, an, seg, dp}, {20'h0, DARK});
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_release_edge1", {20'h0, an, seg, dp}, {20'h0, DARK});
    @(posedge clk);
    #1;
    chk("post_release_edge2", {20'h0, an, seg, dp}, {20'h0, 4'b1110, 7'h19, 1'b1});

    // hex glyphs: digits A, d, E, F from right
    apply_reset(16'hFEDA, 4'hF, 4'h0, 1'b0);
    run_frame("hex", {7'h0E, 7'h06, 7'h21, 7'h08}, 4'hF, 4'h0);

    // leading-zero blanking, then blank_lz dropped live
    apply_reset(16'h0070, 4'hF, 4'h0, 1'b1);
    run_frame("lz_on", {7'h40, 7'h40, 7'h78, 7'h40}, 4'b0011, 4'h0);
    blank_lz = 1'b0;
    run_frame("lz_off", {7'h40, 7'h40, 7'h78, 7'h40}, 4'hF, 4'h0);

    // snapshot coherence: inputs move during slot 1
    apply_reset(16'h0999, 4'hF, 4'h0, 1'b0);
    run_slot("coh_f0", 0, 7'h10, 1'b1, 1'b0);
    digits = 16'h1000;
    run_slot("coh_f0", 1, 7'h10, 1'b1, 1'b0);
    run_slot("coh_f0", 2, 7'h10, 1'b1, 1'b0);
    run_slot("coh_f0", 3, 7'h40, 1'b1, 1'b0);
    run_frame("coh_f1", {7'h79, 7'h40, 7'h40, 7'h40}, 4'hF, 4'h0);

    // per-digit enable and decimal point on digit 1 (5678: d1=7, d3=5)
    apply_reset(16'h5678, 4'b1010, 4'b0010, 1'b0);
    run_frame("en_dp", {7'h12, 7'h02, 7'h78, 7'h00}, 4'b1010, 4'b0010);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
